// File: rtl/dtree_seq_ctrl_if.sv
// Configuration, feature-stream and result handshake bundle for dtree_seq_ctrl.
// The master drives the stimulus and the slave is the classifier.
interface dtree_seq_ctrl_if;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [19:0] cfg_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_class;
  logic        out_err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_class, out_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_class, out_err
  );
endinterface

// File: rtl/dtree_seq_ctrl.sv
// Sequential decision-tree classifier: loads NUM_FEAT feature bytes, walks the node table one node
// per cycle and holds the class until it is accepted. DTREE_SEQ_PERF_CNT_EN enables inf_count.
module dtree_seq_ctrl #(
  parameter int unsigned NUM_FEAT   = 5,
  parameter int unsigned NODE_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  dtree_seq_ctrl_if.slave bus,
  output logic            busy,
  output logic [15:0]     inf_count
);

  localparam int unsigned LdW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int unsigned StW = $clog2(NODE_DEPTH + 1);

  typedef enum logic [1:0] {StLoad, StEval, StDone} state_e;

  state_e           state_q, state_d;
  logic [LdW-1:0]   load_idx_q, load_idx_d;
  logic [3:0]       node_q, node_d;
  logic [StW-1:0]   steps_q, steps_d;
  logic             fetch_q, fetch_d;
  logic [19:0]      ent_q, ent_d;
  logic [4:0]       cls_q, cls_d;
  logic             err_q, err_d;
  logic [7:0]       feat_q [NUM_FEAT];
  logic [7:0]       feat_d [NUM_FEAT];
  logic [19:0]      tbl_q  [NODE_DEPTH];
  logic [19:0]      tbl_d  [NODE_DEPTH];

  logic [7:0]  sel_feat;
  logic        go_left;
  logic [3:0]  nxt_node;
  logic [3:0]  rd_idx;
  logic [19:0] rd_ent;

  // Feature indices beyond the loaded set read as zero.
  always_comb begin
    sel_feat = 8'h00;
    for (int unsigned i = 0; i < NUM_FEAT; i++) begin
      if (32'(ent_q[18:16]) == i) sel_feat = feat_q[i];
    end
  end

  assign go_left  = (sel_feat <= ent_q[15:8]);
  assign nxt_node = go_left ? ent_q[7:4] : ent_q[3:0];

  // The current node entry is held in ent_q; the first EVAL cycle fetches node 0.
  assign rd_idx = fetch_q ? node_q : nxt_node;

  always_comb begin
    rd_ent = '0;
    for (int unsigned i = 0; i < NODE_DEPTH; i++) begin
      if (32'(rd_idx) == i) rd_ent = tbl_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    node_d     = node_q;
    steps_d    = steps_q;
    fetch_d    = fetch_q;
    ent_d      = ent_q;
    cls_d      = cls_q;
    err_d      = err_q;
    feat_d     = feat_q;
    tbl_d      = tbl_q;

    if (bus.cfg_we && state_q != StEval) begin
      for (int unsigned i = 0; i < NODE_DEPTH; i++) begin
        if (32'(bus.cfg_addr) == i) tbl_d[i] = bus.cfg_data;
      end
    end

    case (state_q)
      StLoad: begin
        if (bus.in_valid) begin
          for (int unsigned i = 0; i < NUM_FEAT; i++) begin
            if (32'(load_idx_q) == i) feat_d[i] = bus.in_data;
          end
          if (32'(load_idx_q) == NUM_FEAT - 1) begin
            load_idx_d = '0;
            node_d     = '0;
            steps_d    = '0;
            fetch_d    = 1'b1;
            state_d    = StEval;
          end else begin
            load_idx_d = load_idx_q + 1'b1;
          end
        end
      end
      StEval: begin
        if (fetch_q) begin
          fetch_d = 1'b0;
          ent_d   = rd_ent;
        end else if (ent_q[19]) begin
          cls_d   = ent_q[12:8];
          err_d   = 1'b0;
          state_d = StDone;
        end else if (32'(steps_q) == NODE_DEPTH - 1) begin
          cls_d   = 5'h1F;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          node_d  = nxt_node;
          ent_d   = rd_ent;
          steps_d = steps_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      load_idx_q <= '0;
      node_q     <= '0;
      steps_q    <= '0;
      fetch_q    <= 1'b0;
      ent_q      <= '0;
      cls_q      <= '0;
      err_q      <= 1'b0;
      feat_q     <= '{default: '0};
      tbl_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
      node_q     <= node_d;
      steps_q    <= steps_d;
      fetch_q    <= fetch_d;
      ent_q      <= ent_d;
      cls_q      <= cls_d;
      err_q      <= err_d;
      feat_q     <= feat_d;
      tbl_q      <= tbl_d;
    end
  end

  assign bus.in_ready  = (state_q == StLoad);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_class = cls_q;
  assign bus.out_err   = err_q;
  assign busy          = (state_q != StLoad);

`ifdef DTREE_SEQ_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Error results count too; wraps naturally at 16 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StDone && bus.out_ready) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign inf_count = cnt_q;
`else
  assign inf_count = '0;
`endif

endmodule

// File: tb/tb_dtree_seq_ctrl.sv
// Scoreboard bench for dtree_seq_ctrl: expected results are queued as samples are sent and
// compared (class, error flag, latency) when out_valid appears.
module tb_dtree_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] inf_count;

  always #5 clk = ~clk;

  dtree_seq_ctrl_if bus ();

  dtree_seq_ctrl #(
    .NUM_FEAT  (5),
    .NODE_DEPTH(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .inf_count(inf_count)
  );

  typedef struct {
    logic [4:0] cls;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   exp_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input logic [3:0] addr, input logic [19:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("in_accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic send_sample(input logic [39:0] s);
    for (int i = 0; i < 5; i++) send_byte(s[8*i +: 8]);
  endtask

  task automatic push_exp(input logic [4:0] cls, input logic err, input int lat);
    exp_t e;
    e.cls = cls;
    e.err = err;
    e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Waits for out_valid (bounded) and compares against the scoreboard head.
  task automatic wait_result(input string tag);
    int   k = 0;
    exp_t e;
    while (!bus.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.out_valid) begin
      check({tag, "_valid_timeout"}, {31'd0, bus.out_valid}, 32'd1);
      return;
    end
    if (sb_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_lat"}, 32'(cyc - acc_cyc), 32'(e.lat));
    check({tag, "_cls"}, {27'd0, bus.out_class}, {27'd0, e.cls});
    check({tag, "_err"}, {31'd0, bus.out_err}, {31'd0, e.err});
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic program_tree();
    cfg_wr(4'd0, 20'h43F12);
    cfg_wr(4'd1, 20'h80300);
    cfg_wr(4'd2, 20'h80700);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_class", {27'd0, bus.out_class}, 32'd0);
    check("rst_err", {31'd0, bus.out_err}, 32'd0);
    check("rst_inf_count", {16'd0, inf_count}, 32'd0);

    // Cleared table: every node loops back to node 0 until the step limit.
    push_exp(5'h1F, 1'b1, 17);
    send_sample({8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    @(negedge clk);
    check("eval_busy", {31'd0, busy}, 32'd1);
    check("eval_in_ready", {31'd0, bus.in_ready}, 32'd0);
    wait_result("limit");
    ack();

    program_tree();
    push_exp(5'd3, 1'b0, 3);
    send_sample({8'h3F, 8'h00, 8'h00, 8'h00, 8'h00});
    wait_result("le_thr");
    ack();
    push_exp(5'd7, 1'b0, 3);
    send_sample({8'h40, 8'h00, 8'h00, 8'h00, 8'h00});
    wait_result("gt_thr");

    // Held in DONE: a sixth byte and a table write must not disturb anything.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd2;
    bus.cfg_data = 20'h80C00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_cls", {27'd0, bus.out_class}, 32'd7);
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.cfg_data = 20'h80700;
    ack();
    bus.cfg_we = 1'b0;
    push_exp(5'd7, 1'b0, 3);
    send_sample({8'h40, 8'h3F, 8'h3F, 8'h3F, 8'h3F});
    wait_result("no_sixth");
    ack();

    // Write held from EVAL into DONE: ignored in EVAL, taken in DONE without touching the result.
    push_exp(5'd7, 1'b0, 3);
    send_sample({8'h40, 8'h00, 8'h00, 8'h00, 8'h00});
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd2;
    bus.cfg_data = 20'h80900;
    wait_result("eval_wr");
    ack();
    bus.cfg_we = 1'b0;
    push_exp(5'd9, 1'b0, 3);
    send_sample({8'h40, 8'h00, 8'h00, 8'h00, 8'h00});
    wait_result("after_wr");
    ack();

    // Write coincident with the final byte accept is honoured.
    push_exp(5'd11, 1'b0, 3);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd2;
    bus.cfg_data = 20'h80B00;
    send_byte(8'h40);
    bus.cfg_we = 1'b0;
    wait_result("final_wr");
    ack();
    check("inf_count_pre",
`ifdef DTREE_SEQ_PERF_CNT_EN
          {16'd0, inf_count}, 32'(exp_cnt));
`else
          {16'd0, inf_count}, 32'd0);
`endif

    // Abort a partial sample with reset.
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h40);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_inf_count", {16'd0, inf_count}, 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    program_tree();
    check("abort_no_valid", {31'd0, bus.out_valid}, 32'd0);
    push_exp(5'd7, 1'b0, 3);
    send_sample({8'h40, 8'h10, 8'h10, 8'h10, 8'h10});
    wait_result("fresh");
    ack();

    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("inf_count_end",
`ifdef DTREE_SEQ_PERF_CNT_EN
          {16'd0, inf_count}, 32'(exp_cnt));
`else
          {16'd0, inf_count}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dtree_seq_ctrl.md
DTREE_SEQ_CTRL -- requirements
Module: dtree_seq_ctrl

Interface
REQ-001 Parameter NUM_FEAT, default 5: number of 8-bit features per sample.
REQ-002 Parameter NODE_DEPTH, default 16: node-table entries; also the evaluation step limit.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port cfg_we  input  1: node-table write strobe.
REQ-006 Port cfg_addr  input  4: node-table write index.
REQ-007 Port cfg_data  input  20: node entry {leaf[19], feat_idx[18:16], thr[15:8], left[7:4], right[3:0]}; for a leaf, class = thr[12:8].
REQ-008 Port in_valid / in_ready / in_data  input / output / input  1/1/8: feature byte stream, indices 0..NUM_FEAT-1 in order.
REQ-009 Port out_valid / out_ready / out_class  output / input / output  1/1/5: classification result handshake.
REQ-010 Port out_err  output  1: qualifies out_class; high when the step limit was hit.
REQ-011 Port busy  output  1: high in EVAL and DONE.
REQ-012 Port inf_count  output  16: completed-classification count (see Configuration).

Function
REQ-013 FSM states: LOAD, EVAL, DONE; LOAD after reset.
REQ-014 LOAD: in_ready=1; each in_valid&in_ready cycle stores in_data into feature register[load_idx]; load_idx then increments.
REQ-015 Accepting byte NUM_FEAT-1 moves the FSM to EVAL with node=0, steps=0, load_idx=0.
REQ-016 EVAL: one node per cycle via a single shared 8-bit unsigned comparator.
REQ-017 Internal node: next node = left when feature[feat_idx] <= thr, else right; steps increments.
REQ-018 feat_idx >= NUM_FEAT reads as 0x00.
REQ-019 Leaf node: out_class <= thr[12:8], out_err <= 0, FSM to DONE.
REQ-020 Non-leaf node visited when steps == NODE_DEPTH-1: out_class <= 5'h1F, out_err <= 1, FSM to DONE.
REQ-021 Latency: out_valid rises N+1 cycles after the final accepted byte edge, where N is the count of nodes on the path, leaf included.
REQ-022 DONE: out_valid=1; out_class and out_err held stable until out_valid&out_ready, then FSM to LOAD.
REQ-023 in_ready=0 in EVAL and DONE; out_valid=0 in LOAD and EVAL.
REQ-024 cfg_we is honoured in LOAD and DONE and ignored in EVAL; a write in the same cycle as the final byte accept is honoured.
REQ-025 A cfg write in DONE does not alter the held result.

Reset
REQ-026 rst_n low asynchronously forces: state LOAD, load_idx 0, node 0, steps 0, out_valid 0, out_class 0, out_err 0, busy 0, inf_count 0, all feature registers 0, all node entries 0.
REQ-027 Reset mid-LOAD or mid-EVAL discards partial samples; no result is emitted.

Configuration
REQ-028 Macro DTREE_SEQ_PERF_CNT_EN defined: inf_count increments by 1 on each out_valid&out_ready, wraps 0xFFFF->0, and also counts error results.
REQ-029 Macro DTREE_SEQ_PERF_CNT_EN undefined: inf_count is tied to 0 and the counter logic is not present.

Verification
REQ-030 Cleared table after reset, send bytes 1,2,3,4,5 -> out_valid 17 cycles after the final accept, out_class=0x1F, out_err=1.
REQ-031 Table {0: feat 4, thr 0x3F, L1, R2; 1: leaf class 3; 2: leaf class 7}, features {..,0x3F} -> class 3; then {..,0x40} -> class 7; each with out_valid 3 cycles after the final accept.
REQ-032 Hold out_ready=0 for 10 cycles in DONE -> out_class stable, in_ready=0 throughout, the sixth byte is not accepted.
REQ-033 Write cfg in EVAL changing node 2's class to 9 -> the current result is unchanged (7); the next sample yields 9.
REQ-034 rst_n pulsed low after 3 bytes, then 5 fresh bytes sent -> the result uses only the fresh bytes; out_valid never pulses for the aborted sample.
REQ-035 Macro defined, 3 results accepted -> inf_count=3; macro undefined -> inf_count=0.
